// File: rtl/timing_pulse_sequencer.sv
// Timing pulse sequencer: registered one-hot train of NUM_PULSES timing
// pulses (TP1..TPn) pacing each memory cycle (MCT), with stall, halt at
// cycle boundary, single-cycle step and a wrapping MCT counter.
module timing_pulse_sequencer #(
  parameter int NUM_PULSES = 12,
  parameter int PH_W       = $clog2(NUM_PULSES),
  parameter int MCT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  run,
  input  logic                  step,
  input  logic                  halt,
  input  logic                  stall,
  output logic [NUM_PULSES-1:0] tp,
  output logic [PH_W-1:0]       phase,
  output logic                  active,
  output logic                  mct_end,
  output logic [MCT_W-1:0]      mct_count
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic [PH_W-1:0]       LAST_PHASE = PH_W'(NUM_PULSES - 1);
  localparam logic [NUM_PULSES-1:0] TP_FIRST   = NUM_PULSES'(1);

  state_e                  state_q, state_d;
  logic [PH_W-1:0]         phase_q, phase_d;
  logic [NUM_PULSES-1:0]   tp_q, tp_d;
  logic                    mct_end_q, mct_end_d;
  logic [MCT_W-1:0]        mct_count_q, mct_count_d;
  logic                    single_q, single_d;

  // Next-state and next-output logic for the IDLE/RUN sequencer.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one
    // unassigned; otherwise synthesis infers a latch.
    state_d     = state_q;
    phase_d     = phase_q;
    tp_d        = tp_q;
    mct_end_d   = 1'b0;
    mct_count_d = mct_count_q;
    single_d    = single_q;

    unique case (state_q)
      ST_IDLE: begin
        tp_d    = '0;
        phase_d = '0;
        // run outranks step; stall has no meaning before a cycle starts.
        if (run && !halt) begin
          state_d  = ST_RUN;
          tp_d     = TP_FIRST;
          single_d = 1'b0;
        end else if (step) begin
          state_d  = ST_RUN;
          tp_d     = TP_FIRST;
          single_d = 1'b1;
        end
      end

      ST_RUN: begin
        if (!stall) begin
          if (phase_q == LAST_PHASE) begin
            // Cycle end: halt/run are only honoured here, so a started
            // MCT always runs all of its pulses.
            mct_end_d   = 1'b1;
            mct_count_d = mct_count_q + 1'b1;
            if (single_q || !run || halt) begin
              state_d  = ST_IDLE;
              tp_d     = '0;
              phase_d  = '0;
              single_d = 1'b0;
            end else begin
              phase_d = '0;
              tp_d    = TP_FIRST;
            end
          end else begin
            phase_d = phase_q + 1'b1;
            tp_d    = tp_q << 1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        tp_d    = '0;
        phase_d = '0;
      end
    endcase
  end

  // State and output registers; every output comes straight from here.
  // NOTE: reset is asynchronous so outputs clear immediately, even mid-cycle,
  // and state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      phase_q     <= '0;
      tp_q        <= '0;
      mct_end_q   <= 1'b0;
      mct_count_q <= '0;
      single_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      tp_q        <= tp_d;
      mct_end_q   <= mct_end_d;
      mct_count_q <= mct_count_d;
      single_q    <= single_d;
    end
  end

  assign tp        = tp_q;
  assign phase     = phase_q;
  assign active    = (state_q == ST_RUN);
  assign mct_end   = mct_end_q;
  assign mct_count = mct_count_q;

endmodule

// File: tb/tb_timing_pulse_sequencer.sv
// Bench for timing_pulse_sequencer: a 12-pulse instance checked through an
// MCT scoreboard plus directed checks, and a 9-pulse/4-bit-counter instance
// exercising the legacy cascade and counter wrap.
module tb_timing_pulse_sequencer;

  logic clk = 1'b0;
  logic rst_n;

  // 12-pulse instance
  logic        run, step, halt, stall;
  logic [11:0] tp;
  logic [3:0]  phase;
  logic        active, mct_end;
  logic [15:0] mct_count;

  // 9-pulse instance
  logic        run9, step9, halt9, stall9;
  logic [8:0]  tp9;
  logic [3:0]  phase9;
  logic        active9, mct_end9;
  logic [3:0]  mct_count9;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int unsigned count;
    int unsigned len;
    logic [11:0] next_tp;
    logic        next_active;
  } mct_rec_t;

  mct_rec_t exp_q[$];
  mct_rec_t rec;
  int       len_cnt = 0;

  always #5 clk = ~clk;

  timing_pulse_sequencer #(.NUM_PULSES(12), .MCT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .run(run), .step(step), .halt(halt),
    .stall(stall), .tp(tp), .phase(phase), .active(active),
    .mct_end(mct_end), .mct_count(mct_count)
  );

  timing_pulse_sequencer #(.NUM_PULSES(9), .MCT_W(4)) u_dut9 (
    .clk(clk), .rst_n(rst_n), .run(run9), .step(step9), .halt(halt9),
    .stall(stall9), .tp(tp9), .phase(phase9), .active(active9),
    .mct_end(mct_end9), .mct_count(mct_count9)
  );

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic mct_rec_t mk(int unsigned c, int unsigned l,
                                  logic [11:0] nt, logic na);
    mct_rec_t r;
    r.count = c; r.len = l; r.next_tp = nt; r.next_active = na;
    return r;
  endfunction

  // Monitor: on every retired MCT pop the expected record and compare count,
  // length in clocks (stalls included) and what follows the cycle end.
  always @(negedge clk) begin
    if (!rst_n) begin
      len_cnt = 0;
    end else begin
      if (mct_end) begin
        if (exp_q.size() == 0) begin
          check("mct_end_unexpected", 32'd1, 32'd0);
        end else begin
          rec = exp_q.pop_front();
          check("mct_count", 32'(mct_count), rec.count);
          check("mct_len", 32'(len_cnt), rec.len);
          check("next_tp", 32'(tp), 32'(rec.next_tp));
          check("next_active", 32'(active), 32'(rec.next_active));
        end
        len_cnt = 0;
      end
      if (active) begin
        check("onehot", 32'($onehot(tp)), 32'd1);
        len_cnt++;
      end else begin
        check("idle_tp", 32'(tp), 32'd0);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    run = 1'b0; step = 1'b0; halt = 1'b0; stall = 1'b0;
    run9 = 1'b0; step9 = 1'b0; halt9 = 1'b0; stall9 = 1'b0;

    // Reset values
    #3;
    check("rst_tp", 32'(tp), 32'd0);
    check("rst_phase", 32'(phase), 32'd0);
    check("rst_active", 32'(active), 32'd0);
    check("rst_mct_end", 32'(mct_end), 32'd0);
    check("rst_mct_count", 32'(mct_count), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("idle_after_rst", 32'(tp), 32'd0);

    // Continuous run: two back-to-back MCTs, then a third ended by halt
    exp_q.push_back(mk(1, 12, 12'h001, 1'b1));
    exp_q.push_back(mk(2, 12, 12'h001, 1'b1));
    exp_q.push_back(mk(3, 12, 12'h000, 1'b0));
    run = 1'b1;
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 12; i++) begin
        tick();
        check("walk_tp", 32'(tp), 32'd1 << i);
        if (i == 0 && m == 1) check("walk_mct_end", 32'(mct_end), 32'd1);
        if (i == 11) check("walk_count", 32'(mct_count), 32'(m));
      end
    end

    // Halt raised at phase 5 never truncates the cycle
    for (int i = 0; i < 6; i++) tick();
    check("halt_at_tp6", 32'(tp), 32'h020);
    check("halt_phase", 32'(phase), 32'd5);
    check("halt_count", 32'(mct_count), 32'd2);
    halt = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    check("halt_tp12", 32'(tp), 32'h800);
    tick();
    check("halt_idle_tp", 32'(tp), 32'd0);
    check("halt_idle_active", 32'(active), 32'd0);
    check("halt_count_inc", 32'(mct_count), 32'd3);
    check("halt_mct_end", 32'(mct_end), 32'd1);
    halt = 1'b0;
    exp_q.push_back(mk(4, 12, 12'h000, 1'b0));
    tick();
    check("resume_tp1", 32'(tp), 32'h001);
    check("resume_mct_end", 32'(mct_end), 32'd0);
    run = 1'b0;
    for (int i = 0; i < 11; i++) tick();
    check("runoff_tp12", 32'(tp), 32'h800);
    tick();
    check("runoff_idle", 32'(active), 32'd0);
    check("runoff_count", 32'(mct_count), 32'd4);

    // Single step: one MCT only; a step during the cycle is dropped
    exp_q.push_back(mk(5, 12, 12'h000, 1'b0));
    step = 1'b1;
    tick();
    step = 1'b0;
    check("step_tp1", 32'(tp), 32'h001);
    tick(); tick();
    step = 1'b1;
    tick();
    step = 1'b0;
    check("step_mid_tp", 32'(tp), 32'h008);
    for (int i = 0; i < 8; i++) tick();
    check("step_tp12", 32'(tp), 32'h800);
    tick();
    check("step_done_tp", 32'(tp), 32'd0);
    check("step_count", 32'(mct_count), 32'd5);
    tick();
    check("step_not_queued", 32'(active), 32'd0);

    // Stall 3 clocks at phase 7: TP8 held 4 clocks, MCT is 15 clocks
    exp_q.push_back(mk(6, 15, 12'h000, 1'b0));
    run = 1'b1;
    tick();
    run = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    check("stall_tp8", 32'(tp), 32'h080);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_hold", 32'(tp), 32'h080);
      check("stall_mct_end", 32'(mct_end), 32'd0);
    end
    stall = 1'b0;
    tick();
    check("stall_release", 32'(tp), 32'h100);
    for (int i = 0; i < 3; i++) tick();
    check("stall_tp12", 32'(tp), 32'h800);
    tick();
    check("stall_count", 32'(mct_count), 32'd6);

    // Asynchronous reset at phase 9, then run restarts from TP1
    run = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    check("pre_rst_tp10", 32'(tp), 32'h200);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_tp", 32'(tp), 32'd0);
    check("async_rst_phase", 32'(phase), 32'd0);
    check("async_rst_count", 32'(mct_count), 32'd0);
    check("async_rst_active", 32'(active), 32'd0);
    #2 rst_n = 1'b1;
    exp_q.push_back(mk(1, 12, 12'h000, 1'b0));
    tick();
    check("post_rst_tp1", 32'(tp), 32'h001);
    run = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    check("post_rst_count", 32'(mct_count), 32'd1);
    check("post_rst_idle", 32'(active), 32'd0);

    // Legacy 9-pulse timing, 17 MCTs with a 4-bit counter that wraps
    run9 = 1'b1;
    for (int m = 0; m < 17; m++) begin
      for (int i = 0; i < 9; i++) begin
        tick();
        check("p9_tp", 32'(tp9), 32'd1 << i);
        check("p9_mct_end", 32'(mct_end9), (i == 0 && m > 0) ? 32'd1 : 32'd0);
        if (i == 0) check("p9_count", 32'(mct_count9), 32'(m % 16));
      end
      if (m == 16) run9 = 1'b0;
    end
    tick();
    check("p9_final_count", 32'(mct_count9), 32'd1);
    check("p9_final_tp", 32'(tp9), 32'd0);
    check("p9_final_phase", 32'(phase9), 32'd0);
    check("p9_final_active", 32'(active9), 32'd0);
    check("p9_final_mct_end", 32'(mct_end9), 32'd1);

    tick();
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
